alu_result_queue: RTL and testbench
===================================

Name: alu_result_queue

Overview:
- Downstream buffer for the 16-bit combinational ALU.
- Captures each ALU result (C, OverflowFlag) together with the FuncCode that produced it.
- Holds results in a small in-order FIFO and hands them to the consumer (writeback/test harness) over a valid/ready handshake.
- Keeps a saturating count of accepted results that had overflow set.

Parameters:
- data_width, 16, width of ALU result C
- depth, 4, number of FIFO entries; power of two, ≥2
- ovf_cnt_width, 8, width of saturating overflow counter

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer presents a result this cycle
- in_ready  output  1  queue can accept (= not full)
- in_C  input  data_width  ALU result C
- in_overflow  input  1  ALU OverflowFlag
- in_func  input  4  FuncCode that produced in_C
- out_valid  output  1  head entry available (= not empty)
- out_ready  input  1  consumer takes head this cycle
- out_C  output  data_width  head result
- out_overflow  output  1  head overflow flag
- out_func  output  4  head FuncCode
- count  output  $clog2(depth)+1  current occupancy, 0..depth
- ovf_count  output  ovf_cnt_width  saturating count of accepted overflowing results

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-high. On a rising clk edge with reset=1:
  - read/write pointers and count go to 0;
  - ovf_count goes to 0;
  - any stored entries are discarded.
- Outputs after reset: out_valid=0, in_ready=1, out_C=0, out_overflow=0, out_func=0.
- Reset mid-operation discards in-flight data; a push or pop in the reset cycle is ignored.
- Push: occurs when in_valid && in_ready. {in_C, in_overflow, in_func} is written at the write pointer, the write pointer advances, and count increments.
- Pop: occurs when out_valid && out_ready. The read pointer advances and count decrements.
- Simultaneous push and pop (only possible when 0 < count < depth): both take effect and count is unchanged.
- Full (count==depth):
  - in_ready=0 and in_valid is ignored;
  - no same-cycle bypass, even if out_ready=1;
  - in_ready returns to 1 in the cycle after the pop.
- Empty (count==0):
  - out_valid=0 and out_ready is ignored;
  - out_C/out_overflow/out_func are driven 0;
  - no flow-through: a pushed entry appears on out_* with out_valid=1 one cycle after the push edge (latency 1).
- Outputs are combinational from registered state (pointers, storage, count). There are no combinational paths from in_* to out_*, or from out_ready to in_ready.
- Pointers: log2(depth) bits wide, wrapping modulo depth. Full and empty are derived from count, not from pointer equality.
- Ordering: strict FIFO; entries leave in push order.
- ovf_count:
  - increments by 1 on each accepted push with in_overflow=1;
  - saturates at 2^ovf_cnt_width−1 and holds there;
  - is not affected by pops;
  - is cleared only by reset.
- in_func is stored opaquely; no decoding.

Optional Feature:
- Macro: ALU_RESULT_QUEUE_DROP_OVF_EN
- Defined:
  - an accepted push with in_overflow=1 increments ovf_count but is NOT stored (pointers/count unchanged);
  - in_ready is still !full, so overflowing results are accepted only when not full;
  - out_overflow is then always 0.
- Undefined: all accepted results are stored, as described in Behaviour.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then release → out_valid=0, in_ready=1, count=0, ovf_count=0, out_C=0.
- Single push/pop: push C=16'h1234, func=4'h0, ovf=0 → next cycle out_valid=1, out_C=16'h1234, count=1; pop with out_ready=1 → out_valid=0, count=0.
- Fill and order: out_ready=0, push 16'h0001..16'h0004 on consecutive cycles → count=4, in_ready=0. A 5th push of 16'h0005 is ignored. Then drain → outputs 0001,0002,0003,0004 in order, and in_ready=1 the cycle after the first pop.
- Simultaneous push/pop and wrap: keep count=2 while pushing and popping every cycle for 10 cycles → count stays 2, data order preserved across pointer wrap.
- Overflow counter:
  - 3 accepted pushes with ovf=1 and 1 with ovf=0 → ovf_count=3 (stored entries show out_overflow=1 for those three; with ALU_RESULT_QUEUE_DROP_OVF_EN only the ovf=0 entry is stored, count=1);
  - with ovf_cnt_width=2 and 5 overflow pushes → ovf_count holds at 3.
- Reset mid-operation: count=3 and reset asserted for 1 cycle while in_valid=1 and out_ready=1 → count=0, out_valid=0, ovf_count=0, and no entry from that cycle appears afterward.

Source files
------------

// File: rtl/alu_result_queue.sv
// alu_result_queue: in-order result buffer behind the 16-bit ALU.
// Each accepted {C, OverflowFlag, FuncCode} is queued and handed to the
// consumer over a valid/ready handshake. A saturating counter tracks how
// many accepted results had overflow set.
//
// Optional build macro: ALU_RESULT_QUEUE_DROP_OVF_EN
//   When defined, overflowing results are counted but not stored, and
//   out_overflow is tied to 0.
module alu_result_queue #(
  parameter int data_width    = 16,
  parameter int depth         = 4,
  parameter int ovf_cnt_width = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [data_width-1:0]    in_C,
  input  logic                     in_overflow,
  input  logic [3:0]               in_func,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [data_width-1:0]    out_C,
  output logic                     out_overflow,
  output logic [3:0]               out_func,
  output logic [$clog2(depth):0]   count,
  output logic [ovf_cnt_width-1:0] ovf_count
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;

  typedef struct packed {
    logic [data_width-1:0] c;
    logic                  ovf;
    logic [3:0]            func;
  } entry_t;

  entry_t                   r_mem [depth];
  logic [ptr_w-1:0]         r_wr_ptr;
  logic [ptr_w-1:0]         r_rd_ptr;
  logic [cnt_w-1:0]         r_count;
  logic [ovf_cnt_width-1:0] r_ovf_count;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_store;
  logic [cnt_w-1:0]         w_count_next;
  entry_t                   w_head;
  entry_t                   w_in_entry;

  // Full/empty come from the occupancy count, so pointer equality is never ambiguous.
  assign w_full  = (r_count == cnt_w'(depth));
  assign w_empty = (r_count == '0);

  // A push is only accepted when not full; there is no bypass through a full queue.
  assign w_push = in_valid && !w_full;
  assign w_pop  = out_ready && !w_empty;

`ifdef ALU_RESULT_QUEUE_DROP_OVF_EN
  // Overflowing results are accepted (and counted) but never enter storage.
  assign w_store = w_push && !in_overflow;
`else
  assign w_store = w_push;
`endif

  assign w_in_entry = '{c: in_C, ovf: in_overflow, func: in_func};

  // Next occupancy: store and pop together leave the count unchanged.
  always_comb begin
    // NOTE: default first so every path assigns w_count_next; otherwise a latch is inferred.
    w_count_next = r_count;
    case ({w_store, w_pop})
      2'b10:   w_count_next = r_count + cnt_w'(1);
      2'b01:   w_count_next = r_count - cnt_w'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointer, occupancy and overflow-counter state with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf_count <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + ptr_w'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + ptr_w'(1);
      r_count <= w_count_next;
      if (w_push && in_overflow && (r_ovf_count != '1))
        r_ovf_count <= r_ovf_count + ovf_cnt_width'(1);
    end
  end

  // Entry storage write; stale contents are masked by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; it maps onto plain RAM/flops without reset muxes.
    if (w_store && !reset) r_mem[r_wr_ptr] <= w_in_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  // Outputs are functions of registered state only; head fields read 0 when empty.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_C     = w_empty ? '0 : w_head.c;
  assign out_func  = w_empty ? '0 : w_head.func;
`ifdef ALU_RESULT_QUEUE_DROP_OVF_EN
  assign out_overflow = 1'b0;
`else
  assign out_overflow = w_empty ? 1'b0 : w_head.ovf;
`endif
  assign count     = r_count;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: table-driven vectors for the
// basic push/pop/fill sequence, plus hand-written sequences for wrap,
// overflow counting/saturation and reset in mid-operation.
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_C;
  logic        in_overflow;
  logic [3:0]  in_func;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_C;
  logic        out_overflow;
  logic [3:0]  out_func;
  logic [2:0]  count;
  logic [7:0]  ovf_count;

  // Second instance with a 2-bit overflow counter, sharing the inputs.
  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_C;
  logic        s_out_overflow;
  logic [3:0]  s_out_func;
  logic [2:0]  s_count;
  logic [1:0]  s_ovf_count;

  int tests  = 0;
  int errors = 0;

  alu_result_queue #(.data_width(16), .depth(4), .ovf_cnt_width(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_C(in_C), .in_overflow(in_overflow), .in_func(in_func),
    .out_valid(out_valid), .out_ready(out_ready), .out_C(out_C),
    .out_overflow(out_overflow), .out_func(out_func), .count(count),
    .ovf_count(ovf_count)
  );

  alu_result_queue #(.data_width(16), .depth(4), .ovf_cnt_width(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_C(in_C), .in_overflow(in_overflow), .in_func(in_func),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_C(s_out_C),
    .out_overflow(s_out_overflow), .out_func(s_out_func), .count(s_count),
    .ovf_count(s_ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] c;
    logic        ovf;
    logic [3:0]  f;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [15:0] e_c;
    logic [3:0]  e_f;
    logic [2:0]  e_cnt;
    logic [7:0]  e_oc;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge happen, settle.
  task automatic step(input logic rst, input logic iv, input logic [15:0] c,
                      input logic ovf, input logic [3:0] f, input logic ordy);
    @(negedge clk);
    reset       = rst;
    in_valid    = iv;
    in_C        = c;
    in_overflow = ovf;
    in_func     = f;
    out_ready   = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
  endtask

  logic [15:0] model_q [$];
  logic [15:0] nxt;
  logic [15:0] exp_c   [4];
  logic        exp_ovf [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_C = '0; in_overflow = 1'b0;
    in_func = '0; out_ready = 1'b0;

    //          rst  iv    c       ovf   f     ordy  e_ov  e_ir  e_c      e_f   e_cnt e_oc
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 3'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 3'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 3'd0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 16'h1234, 4'h0, 3'd1, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0, 3'd0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 16'h0001, 4'h1, 3'd1, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 4'h2, 1'b0, 1'b1, 1'b1, 16'h0001, 4'h1, 3'd2, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0003, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 16'h0001, 4'h1, 3'd3, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0004, 1'b0, 4'h4, 1'b0, 1'b1, 1'b0, 16'h0001, 4'h1, 3'd4, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 16'h0005, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 16'h0001, 4'h1, 3'd4, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 16'h0005, 1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 16'h0002, 4'h2, 3'd3, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0003, 4'h3, 3'd2, 8'd0};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0004, 4'h4, 3'd1, 8'd0};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0, 3'd0, 8'd0};

    // Reset, single push/pop, fill to full with ignored 5th push, drain.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].c, vecs[i].ovf, vecs[i].f, vecs[i].ordy);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      check($sformatf("vec%0d out_C", i),     32'(out_C),     32'(vecs[i].e_c));
      check($sformatf("vec%0d out_func", i),  32'(out_func),  32'(vecs[i].e_f));
      check($sformatf("vec%0d out_ovf", i),   32'(out_overflow), 32'(1'b0));
      check($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
      check($sformatf("vec%0d ovf_count", i), 32'(ovf_count), 32'(vecs[i].e_oc));
    end

    // Simultaneous push/pop at count=2 for 10 cycles; pointers wrap.
    model_q = {};
    for (int i = 0; i < 2; i++) begin
      nxt = 16'hA000 + 16'(i);
      step(1'b0, 1'b1, nxt, 1'b0, 4'h7, 1'b0);
      model_q.push_back(nxt);
    end
    check("pp prefill count", 32'(count), 32'd2);
    for (int i = 2; i < 12; i++) begin
      nxt = 16'hA000 + 16'(i);
      step(1'b0, 1'b1, nxt, 1'b0, 4'h7, 1'b1);
      model_q.push_back(nxt);
      void'(model_q.pop_front());
      check($sformatf("pp%0d count", i), 32'(count), 32'd2);
      check($sformatf("pp%0d head", i),  32'(out_C), 32'(model_q[0]));
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pp drain%0d head", i), 32'(out_C), 32'(model_q[0]));
      void'(model_q.pop_front());
      step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    end
    check("pp drained valid", 32'(out_valid), 32'd0);

    // Overflow counting: three overflowing pushes, one clean push.
    step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0010, 1'b1, 4'h2, 1'b0);
    step(1'b0, 1'b1, 16'h0011, 1'b1, 4'h3, 1'b0);
    step(1'b0, 1'b1, 16'h0012, 1'b1, 4'h4, 1'b0);
    step(1'b0, 1'b1, 16'h0013, 1'b0, 4'h5, 1'b0);
    check("ovf count3", 32'(ovf_count), 32'd3);
`ifdef ALU_RESULT_QUEUE_DROP_OVF_EN
    check("ovf drop count", 32'(count), 32'd1);
    check("ovf drop head", 32'(out_C), 32'h0013);
    check("ovf drop head ovf", 32'(out_overflow), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
`else
    check("ovf keep count", 32'(count), 32'd4);
    exp_c   = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    exp_ovf = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf head%0d C", i),   32'(out_C),        32'(exp_c[i]));
      check($sformatf("ovf head%0d ovf", i), 32'(out_overflow), 32'(exp_ovf[i]));
      step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    end
`endif
    check("ovf pops keep count", 32'(ovf_count), 32'd3);
    check("ovf drained", 32'(count), 32'd0);

    // Saturation: five overflow pushes into a 2-bit counter.
    step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0030 + 16'(i), 1'b1, 4'h1, 1'b1);
    idle();
    check("sat 2bit holds", 32'(s_ovf_count), 32'd3);
    check("sat 8bit counts", 32'(ovf_count), 32'd5);

    // Reset mid-operation with a push and pop in the reset cycle.
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0021 + 16'(i), 1'b0, 4'h6, 1'b0);
    check("mid pre count", 32'(count), 32'd3);
    step(1'b1, 1'b1, 16'h0099, 1'b0, 4'h9, 1'b1);
    check("mid rst count", 32'(count), 32'd0);
    check("mid rst valid", 32'(out_valid), 32'd0);
    check("mid rst ovf_count", 32'(ovf_count), 32'd0);
    check("mid rst out_C", 32'(out_C), 32'd0);
    idle();
    check("mid post count", 32'(count), 32'd0);
    check("mid post valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 16'h0055, 1'b0, 4'hA, 1'b0);
    check("mid fresh head", 32'(out_C), 32'h0055);
    check("mid fresh func", 32'(out_func), 32'hA);
    check("mid fresh count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
